// File: rtl/pcileech_com_pkg.sv
// Shared constants, injection state type and counter helper for the
// PCILeech communication receive path.
package pcileech_com_pkg;

  // Default in-band resync word; the stream realigns when the shift register equals it.
  localparam logic [63:0] COM_SYNC_PATTERN_DEFAULT = 64'h66665555_66665555;

  // Default number of cycles after reset release before the first injected word.
  localparam int COM_INIT_DELAY_DEFAULT = 16;

  // Default injected words, packed with word i at bits [i*64 +: 64].
  // Words 0..3 are zero and the last word (index 4) sits in the top 64 bits.
  localparam logic [319:0] COM_INIT_DATA_DEFAULT = {64'h00000003_80182377, 256'h0};

  // Injection sequencer states.
  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    INJECT = 2'd1,
    DONE   = 2'd2
  } com_inj_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat16_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pcileech_com_rx_fifo.sv
// Small synchronous first-word-fall-through FIFO. The head entry is visible
// on dout whenever empty is low. A push is accepted when the FIFO is not full,
// or when it is full and a pop happens on the same edge.
module pcileech_com_rx_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_wr;
  logic             do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd = pop && !empty;
  assign do_wr = push && (!full || do_rd);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write. On a full push+pop the freed head slot is the tail slot.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pcileech_com_rx_packer.sv
// Receive packer: shifts 1/2/4-byte input beats into OUT_BYTES-wide command
// words, realigns on the in-band sync word, injects a fixed sequence of
// initial words after reset, and presents everything over valid/ready.
//
// Output handshake: a word transfers on a rising clk edge where
// dout_valid & dout_ready are both high. While dout_valid is high and
// dout_ready is low, dout and dout_valid hold their values. Input beats
// have no backpressure: every din_valid beat is consumed.
module pcileech_com_rx_packer
  import pcileech_com_pkg::*;
#(
  parameter int                                        IN_BYTES     = 1,
  parameter int                                        OUT_BYTES    = 8,
  parameter logic [OUT_BYTES*8-1:0]                    SYNC_PATTERN = COM_SYNC_PATTERN_DEFAULT,
  parameter int                                        INIT_WORDS   = 5,
  parameter logic [((INIT_WORDS > 0) ? INIT_WORDS : 1)*OUT_BYTES*8-1:0] INIT_DATA = COM_INIT_DATA_DEFAULT,
  parameter int                                        INIT_DELAY   = COM_INIT_DELAY_DEFAULT,
  parameter int                                        FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*IN_BYTES-1:0]  din,
  input  logic                   din_valid,
  output logic [8*OUT_BYTES-1:0] dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   init_done,
  output logic [15:0]            drop_cnt,
  output logic [15:0]            sync_cnt,
  output com_inj_state_t         dbg_state
);

  localparam int W     = OUT_BYTES * 8;
  localparam int IW    = IN_BYTES * 8;
  localparam int BEATS = OUT_BYTES / IN_BYTES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int NW    = (INIT_WORDS > 0) ? INIT_WORDS : 1;
  localparam int XW    = (NW > 1) ? $clog2(NW) : 1;

  logic [W-1:0]   sr_q;
  logic [W-1:0]   sr_next;
  logic [CW-1:0]  cnt_q;
  logic [15:0]    drop_cnt_q;
  logic [15:0]    sync_cnt_q;
  com_inj_state_t state_q;
  logic [31:0]    dly_q;
  logic [XW-1:0]  idx_q;

  logic           resync;
  logic           complete;
  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic           drop;
  logic [W-1:0]   fifo_dout;
  logic [W-1:0]   init_word;

  // Next shift-register value: newest beat enters the least significant lane.
  assign sr_next   = (sr_q << IW) | W'(din);
  // A sync match wins over word completion so the sync word itself is never emitted.
  assign resync    = din_valid && (sr_next == SYNC_PATTERN);
  assign complete  = din_valid && !resync && (cnt_q == CW'(BEATS - 1));
  // Stream words only leave the buffer once injection has finished.
  assign fifo_pop  = (state_q == DONE) && !fifo_empty && dout_ready;
  assign fifo_push = complete;
  assign drop      = complete && fifo_full && !fifo_pop;
  assign init_word = INIT_DATA[int'(idx_q) * W +: W];

  // Beat counting, shift register and saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      drop_cnt_q <= '0;
      sync_cnt_q <= '0;
    end else begin
      if (din_valid) begin
        sr_q <= sr_next;
        if (resync || complete) cnt_q <= '0;
        else                    cnt_q <= cnt_q + 1'b1;
      end
      if (resync) sync_cnt_q <= sat16_inc(sync_cnt_q);
      if (drop)   drop_cnt_q <= sat16_inc(drop_cnt_q);
    end
  end

  // Injection sequencer: wait INIT_DELAY cycles, hand out INIT_WORDS words, then stay done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT;
      dly_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        WAIT: begin
          if (INIT_WORDS == 0) begin
            state_q <= DONE;
          end else if (dly_q + 32'd1 >= 32'(INIT_DELAY)) begin
            state_q <= INJECT;
          end else begin
            dly_q <= dly_q + 32'd1;
          end
        end
        INJECT: begin
          if (dout_ready) begin
            if (idx_q == XW'(INIT_WORDS - 1)) state_q <= DONE;
            else                              idx_q   <= idx_q + 1'b1;
          end
        end
        DONE:    state_q <= DONE;
        default: state_q <= WAIT;
      endcase
    end
  end

  // Output ownership: injected words during INJECT, buffered stream words once DONE.
  always_comb begin
    dout       = '0;
    dout_valid = 1'b0;
    if (state_q == INJECT) begin
      dout       = init_word;
      dout_valid = 1'b1;
    end else if (state_q == DONE && !fifo_empty) begin
      dout       = fifo_dout;
      dout_valid = 1'b1;
    end
  end

  assign init_done = (state_q == DONE);
  assign drop_cnt  = drop_cnt_q;
  assign sync_cnt  = sync_cnt_q;
  assign dbg_state = state_q;

  pcileech_com_rx_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (sr_next),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_pcileech_com_rx_packer.sv
// Bench for pcileech_com_rx_packer. Three instances:
//   a: IN_BYTES=1, no injection (packing, resync, overflow, reset mid-word)
//   b: IN_BYTES=4, no injection (wide beats)
//   c: default parameters (injection timing, ordering, init_done)
module tb_pcileech_com_rx_packer;
  import pcileech_com_pkg::*;

  // ---------------- clock ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- DUT a ----------------
  logic rst_a, din_valid_a, dout_valid_a, dout_ready_a, init_done_a;
  logic [7:0] din_a;
  logic [63:0] dout_a;
  logic [15:0] drop_cnt_a, sync_cnt_a;
  com_inj_state_t dbg_state_a;

  pcileech_com_rx_packer #(
    .IN_BYTES(1), .OUT_BYTES(8), .INIT_WORDS(0), .INIT_DATA(64'h0), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .rst(rst_a), .din(din_a), .din_valid(din_valid_a),
    .dout(dout_a), .dout_valid(dout_valid_a), .dout_ready(dout_ready_a),
    .init_done(init_done_a), .drop_cnt(drop_cnt_a), .sync_cnt(sync_cnt_a),
    .dbg_state(dbg_state_a)
  );

  // ---------------- DUT b ----------------
  logic rst_b, din_valid_b, dout_valid_b, dout_ready_b, init_done_b;
  logic [31:0] din_b;
  logic [63:0] dout_b;
  logic [15:0] drop_cnt_b, sync_cnt_b;
  com_inj_state_t dbg_state_b;

  pcileech_com_rx_packer #(
    .IN_BYTES(4), .OUT_BYTES(8), .INIT_WORDS(0), .INIT_DATA(64'h0), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst(rst_b), .din(din_b), .din_valid(din_valid_b),
    .dout(dout_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready_b),
    .init_done(init_done_b), .drop_cnt(drop_cnt_b), .sync_cnt(sync_cnt_b),
    .dbg_state(dbg_state_b)
  );

  // ---------------- DUT c ----------------
  logic rst_c, din_valid_c, dout_valid_c, dout_ready_c, init_done_c;
  logic [7:0] din_c;
  logic [63:0] dout_c;
  logic [15:0] drop_cnt_c, sync_cnt_c;
  com_inj_state_t dbg_state_c;

  pcileech_com_rx_packer dut_c (
    .clk(clk), .rst(rst_c), .din(din_c), .din_valid(din_valid_c),
    .dout(dout_c), .dout_valid(dout_valid_c), .dout_ready(dout_ready_c),
    .init_done(init_done_c), .drop_cnt(drop_cnt_c), .sync_cnt(sync_cnt_c),
    .dbg_state(dbg_state_c)
  );

  // ---------------- scoreboards ----------------
  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];
  logic [63:0] exp_c[$];

  // A word transfers at the next posedge when valid & ready are seen here.
  always @(negedge clk) begin
    if (dout_valid_a && dout_ready_a) begin
      if (exp_a.size() == 0) chk("a_unexpected_word", {63'd0, dout_valid_a}, 64'd0);
      else                   chk("a_word", dout_a, exp_a.pop_front());
    end
    if (dout_valid_b && dout_ready_b) begin
      if (exp_b.size() == 0) chk("b_unexpected_word", {63'd0, dout_valid_b}, 64'd0);
      else                   chk("b_word", dout_b, exp_b.pop_front());
    end
    if (dout_valid_c && dout_ready_c) begin
      if (exp_c.size() == 0) chk("c_unexpected_word", {63'd0, dout_valid_c}, 64'd0);
      else                   chk("c_word", dout_c, exp_c.pop_front());
    end
  end

  function automatic int qsize(input int which);
    case (which)
      0:       return exp_a.size();
      1:       return exp_b.size();
      default: return exp_c.size();
    endcase
  endfunction

  // Wait (bounded) for a scoreboard to empty, then idle a few cycles to catch extras.
  task automatic drain(input int which, input string tag);
    int n;
    n = 0;
    while (qsize(which) != 0 && n < 60) begin
      tick();
      n++;
    end
    chk(tag, 64'(qsize(which)), 64'd0);
    repeat (3) tick();
  endtask

  // ---------------- drivers ----------------
  task automatic send_a(input logic [7:0] b);
    din_a = b;
    din_valid_a = 1'b1;
    tick();
    din_valid_a = 1'b0;
  endtask

  task automatic send_word_a(input logic [63:0] w);
    for (int i = 0; i < 8; i++) send_a(w[63-8*i -: 8]);
  endtask

  task automatic send_b(input logic [31:0] b);
    din_b = b;
    din_valid_b = 1'b1;
    tick();
    din_valid_b = 1'b0;
  endtask

  task automatic send_c(input logic [7:0] b);
    din_c = b;
    din_valid_c = 1'b1;
    tick();
    din_valid_c = 1'b0;
  endtask

  // Word whose bytes are base, base+1, ..., base+7 (first byte most significant).
  function automatic logic [63:0] ramp(input logic [7:0] base);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[63-8*i -: 8] = base + 8'(i);
    return w;
  endfunction

  // ---------------- instance a sequence ----------------
  task automatic run_a();
    logic [63:0] w;
    logic [63:0] sync_w;
    sync_w = COM_SYNC_PATTERN_DEFAULT;
    rst_a = 1'b1; din_a = '0; din_valid_a = 1'b0; dout_ready_a = 1'b1;
    repeat (2) tick();
    chk("a_rst_dout", dout_a, 64'd0);
    chk("a_rst_valid", {63'd0, dout_valid_a}, 64'd0);
    chk("a_rst_init_done", {63'd0, init_done_a}, 64'd0);
    chk("a_rst_drop", {48'd0, drop_cnt_a}, 64'd0);
    chk("a_rst_sync", {48'd0, sync_cnt_a}, 64'd0);
    rst_a = 1'b0;
    tick();
    chk("a_init_done_no_inject", {63'd0, init_done_a}, 64'd1);

    // Packing 01..08, valid one cycle after the final beat.
    exp_a.push_back(64'h01020304_05060708);
    for (int i = 1; i <= 8; i++) send_a(8'(i));
    chk("a_pack_latency", {63'd0, dout_valid_a}, 64'd1);
    drain(0, "a_pack_drain");
    chk("a_pack_sync_cnt", {48'd0, sync_cnt_a}, 64'd0);

    // Resync after garbage. The eighth byte closes a word on the old alignment
    // (AA BB CC + first five sync bytes); the sync match then realigns so the
    // following 11..18 come out as one clean word.
    exp_a.push_back(64'hAABBCC66_66555566);
    exp_a.push_back(64'h11121314_15161718);
    send_a(8'hAA); send_a(8'hBB); send_a(8'hCC);
    send_word_a(sync_w);
    send_word_a(64'h11121314_15161718);
    drain(0, "a_resync_drain");
    chk("a_resync_sync_cnt", {48'd0, sync_cnt_a}, 64'd1);

    // Sync landing exactly on a word boundary: no word, counter increments.
    send_word_a(sync_w);
    exp_a.push_back(ramp(8'hC1));
    send_word_a(ramp(8'hC1));
    drain(0, "a_aligned_sync_drain");
    chk("a_aligned_sync_cnt", {48'd0, sync_cnt_a}, 64'd2);

    // Overflow: ready low, six words into a four-deep buffer.
    dout_ready_a = 1'b0;
    for (int k = 0; k < 6; k++) begin
      w = ramp(8'h40 + 8'(8 * k));
      if (k < 4) exp_a.push_back(w);
      send_word_a(w);
    end
    chk("a_overflow_drop_cnt", {48'd0, drop_cnt_a}, 64'd2);
    for (int k = 0; k < 3; k++) begin
      chk("a_stall_valid", {63'd0, dout_valid_a}, 64'd1);
      chk("a_stall_dout", dout_a, ramp(8'h40));
      tick();
    end
    dout_ready_a = 1'b1;
    drain(0, "a_overflow_drain");

    // Push into a full buffer on the same edge as a pop: accepted, no drop.
    dout_ready_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w = ramp(8'h70 + 8'(8 * k));
      exp_a.push_back(w);
      send_word_a(w);
    end
    w = ramp(8'hA0);
    exp_a.push_back(w);
    for (int i = 0; i < 7; i++) send_a(w[63-8*i -: 8]);
    dout_ready_a = 1'b1;
    send_a(w[7:0]);
    drain(0, "a_full_pushpop_drain");
    chk("a_full_pushpop_drop_cnt", {48'd0, drop_cnt_a}, 64'd2);

    // Reset in the middle of a word clears the partial word and counters.
    for (int i = 0; i < 5; i++) send_a(8'h90 + 8'(i));
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("a_midrst_drop", {48'd0, drop_cnt_a}, 64'd0);
    chk("a_midrst_sync", {48'd0, sync_cnt_a}, 64'd0);
    chk("a_midrst_valid", {63'd0, dout_valid_a}, 64'd0);
    tick();
    exp_a.push_back(64'h21222324_25262728);
    for (int i = 0; i < 8; i++) send_a(8'h21 + 8'(i));
    drain(0, "a_midrst_drain");
  endtask

  // ---------------- instance b sequence ----------------
  task automatic run_b();
    rst_b = 1'b1; din_b = '0; din_valid_b = 1'b0; dout_ready_b = 1'b1;
    repeat (2) tick();
    rst_b = 1'b0;
    tick();
    exp_b.push_back(64'hAABBCCDD_00112233);
    send_b(32'hAABBCCDD);
    send_b(32'h00112233);
    chk("b_latency", {63'd0, dout_valid_b}, 64'd1);
    exp_b.push_back(64'h01020304_05060708);
    send_b(32'h01020304);
    send_b(32'h05060708);
    drain(1, "b_drain");
    chk("b_drop_cnt", {48'd0, drop_cnt_b}, 64'd0);
  endtask

  // ---------------- instance c sequence ----------------
  task automatic run_c();
    rst_c = 1'b1; din_c = '0; din_valid_c = 1'b0; dout_ready_c = 1'b1;
    repeat (2) tick();
    chk("c_rst_state", 64'(dbg_state_c), 64'(WAIT));
    chk("c_rst_init_done", {63'd0, init_done_c}, 64'd0);
    chk("c_rst_valid", {63'd0, dout_valid_c}, 64'd0);
    for (int i = 0; i < 4; i++) exp_c.push_back(64'd0);
    exp_c.push_back(64'h00000003_80182377);
    exp_c.push_back(ramp(8'hD1));
    rst_c = 1'b0;
    // Edges 1..8 after release: a stream word completes during WAIT.
    for (int i = 0; i < 8; i++) send_c(8'hD1 + 8'(i));
    chk("c_wait_holds_stream", {63'd0, dout_valid_c}, 64'd0);
    repeat (7) tick();
    chk("c_before_inject_valid", {63'd0, dout_valid_c}, 64'd0);
    tick();
    chk("c_inject_valid", {63'd0, dout_valid_c}, 64'd1);
    chk("c_inject_state", 64'(dbg_state_c), 64'(INJECT));
    repeat (4) tick();
    chk("c_init_done_before_last", {63'd0, init_done_c}, 64'd0);
    chk("c_last_init_word", dout_c, 64'h00000003_80182377);
    tick();
    chk("c_init_done_after_last", {63'd0, init_done_c}, 64'd1);
    chk("c_done_state", 64'(dbg_state_c), 64'(DONE));
    drain(2, "c_drain");
    chk("c_drop_cnt", {48'd0, drop_cnt_c}, 64'd0);
  endtask

  initial begin
    fork
      run_a();
      run_b();
      run_c();
    join
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
